// File: rtl/slide_pkg.sv
// Shared constants and types for the ED25519 sliding-window recoder/decoder pair.
package slide_pkg;

  localparam int N_DIGITS  = 256;
  localparam int DIGIT_W   = 5;
  localparam int DIGIT_MIN = -15;
  localparam int DIGIT_MAX = 15;
  // |sum r[i]*2^i| < 16*2^N_DIGITS, so six guard bits above the scalar hold it signed.
  localparam int ACC_W     = N_DIGITS + 6;
  localparam int IDX_W     = $clog2(N_DIGITS);
  localparam int NZ_W      = $clog2(N_DIGITS + 1);

  typedef logic signed [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/slide_digit_check.sv
// Classifies one signed recoder digit: nonzero, and non-canonical
// (even and nonzero, or the unreachable value -16).
module slide_digit_check
  import slide_pkg::*;
(
  input  digit_t d_i,
  output logic   nonzero_o,
  output logic   bad_o
);

  localparam digit_t DIGIT_NEG16 = digit_t'(5'b10000);

  // A canonical digit is zero or odd within [-15, 15].
  always_comb begin
    nonzero_o = (d_i != '0);
    bad_o     = (d_i == DIGIT_NEG16) || ((d_i != '0) && !d_i[0]);
  end

endmodule

// File: rtl/slide_decode_rtl.sv
// Reconstructs a scalar from its signed sliding-window digits by Horner
// evaluation, most significant digit first, one digit per clock.
module slide_decode_rtl
  import slide_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [N_DIGITS-1:0][DIGIT_W-1:0]     r,
  output logic [N_DIGITS-1:0]                  a_out,
  output logic [NZ_W-1:0]                      nz_count,
  output logic                                 err_digit,
  output logic                                 err_range,
  output logic                                 busy,
  output logic                                 done
);

  dec_state_t state_q, state_d;

  logic [N_DIGITS-1:0][DIGIT_W-1:0] bank_q;
  logic signed [ACC_W-1:0]          acc_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [NZ_W-1:0]                  nz_q;
  logic                             bad_seen_q;

  logic [N_DIGITS-1:0]              a_out_q;
  logic [NZ_W-1:0]                  nz_count_q;
  logic                             err_digit_q;
  logic                             err_range_q;
  logic                             busy_q;
  logic                             done_q;

  logic   load, step, fin;
  digit_t cur_digit;
  logic   cur_nonzero, cur_bad;

  function automatic logic signed [ACC_W-1:0] sext_digit(input digit_t d);
    return {{(ACC_W-DIGIT_W){d[DIGIT_W-1]}}, d};
  endfunction

  // Anything at or above 2^N_DIGITS, or any negative value, is not a valid scalar.
  function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] | (|v[ACC_W-2:N_DIGITS]);
  endfunction

  assign cur_digit = digit_t'(bank_q[idx_q]);

  slide_digit_check u_check (
    .d_i       (cur_digit),
    .nonzero_o (cur_nonzero),
    .bad_o     (cur_bad)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a start is only honoured from IDLE, so a pulse mid-run or in FIN is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (idx_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes for the datapath, decoded from the current state.
  always_comb begin
    load = (state_q == IDLE) && start;
    step = (state_q == ACC);
    fin  = (state_q == FIN);
  end

  // Datapath: capture digits on start, accumulate per digit, publish results at FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      nz_q        <= '0;
      bad_seen_q  <= 1'b0;
      a_out_q     <= '0;
      nz_count_q  <= '0;
      err_digit_q <= 1'b0;
      err_range_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (load) begin
        bank_q      <= r;
        acc_q       <= '0;
        idx_q       <= IDX_W'(N_DIGITS - 1);
        nz_q        <= '0;
        bad_seen_q  <= 1'b0;
        err_digit_q <= 1'b0;
        err_range_q <= 1'b0;
        done_q      <= 1'b0;
        busy_q      <= 1'b1;
      end
      if (step) begin
        acc_q <= (acc_q <<< 1) + sext_digit(cur_digit);
        nz_q  <= nz_q + NZ_W'(cur_nonzero);
        if (cur_bad) bad_seen_q <= 1'b1;
        if (idx_q != '0) idx_q <= idx_q - 1'b1;
      end
      if (fin) begin
        a_out_q     <= acc_q[N_DIGITS-1:0];
        nz_count_q  <= nz_q;
        err_digit_q <= bad_seen_q;
        err_range_q <= out_of_range(acc_q);
        done_q      <= 1'b1;
        busy_q      <= 1'b0;
      end
    end
  end

  assign a_out     = a_out_q;
  assign nz_count  = nz_count_q;
  assign err_digit = err_digit_q;
  assign err_range = err_range_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
